shared_counter_arbiter: RTL and testbench



---
 rtl/shared_counter_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/shared_counter_arbiter.sv | 83 ++++++++
 tb/tb_shared_counter_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/shared_counter_pkg.sv
// shared_counter_pkg: shared types, defaults and helpers for the shared counter scheduler
package shared_counter_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [7:0] onehot(input logic [2:0] index);
    return 8'(1) << index;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner
);
  logic found;
  int j;
  // scan from ptr upward with wrap; the first hit wins
  always_comb begin
    found = 1'b0;
    winner = '0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        winner = IW'(j);
        found = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/shared_counter_arbiter.sv
// shared_counter_arbiter: one down-counter shared round-robin among NREQ requesters
module shared_counter_arbiter
  import shared_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  tick,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, owner, owner_n, winner, ptr_adv;
  logic [WIDTH-1:0] count_n, win_load;
  logic [NREQ-1:0] grant_n, done_n;
  logic valid, busy_n;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(ptr),
    .valid(valid),
    .winner(winner)
  );
  assign win_load = load_val[int'(winner)*WIDTH +: WIDTH];
  assign ptr_adv = IW'((int'(owner) + 1) % NREQ);
  // next-state: grant in IDLE, count in RUN, release after DONE or on abort
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    count_n = count;
    grant_n = grant;
    if (state == IDLE) begin
      if (valid) begin
        grant_n = NREQ'(onehot(3'(winner)));
        count_n = win_load;
        owner_n = winner;
        state_n = (win_load != '0) ? RUN : DONE;
      end
    end else if (abort) begin
      state_n = IDLE;
      grant_n = '0;
      count_n = '0;
      ptr_n = ptr_adv;
    end else if (state == DONE) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = ptr_adv;
    end else if (tick && count != '0) begin
      count_n = count - WIDTH'(1);
      state_n = (count == WIDTH'(1)) ? DONE : RUN;
    end
    busy_n = state_n != IDLE;
    done_n = (state_n == DONE) ? grant_n : '0;
  end
  // all state and outputs are flops so nothing leaks combinationally from inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      count <= '0;
      grant <= '0;
      busy <= 1'b0;
      done <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      count <= count_n;
      grant <= grant_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_shared_counter_arbiter.sv
// tb_shared_counter_arbiter: directed plus random checks against a behavioural job model
module tb_shared_counter_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ = 2;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] load_val;
  logic tick, abort;
  logic [NREQ-1:0] grant, done;
  logic busy;
  logic [WIDTH-1:0] count;
  int n_chk = 0;
  int n_fail = 0;
  int m_own = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_fin = 0;
  shared_counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .load_val(load_val),
    .tick(tick),
    .abort(abort),
    .grant(grant),
    .busy(busy),
    .count(count),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_step(input logic r, input logic [NREQ-1:0] q,
                            input logic [NREQ*WIDTH-1:0] lv, input logic t, input logic a);
    int i;
    if (r) begin
      m_own = -1; m_cnt = 0; m_ptr = 0; m_fin = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (q[i] && m_own < 0) begin
          m_own = i;
          m_cnt = int'((lv >> (i * WIDTH)) & ((1 << WIDTH) - 1));
          m_fin = (m_cnt == 0);
        end
      end
    end else if (a) begin
      m_ptr = (m_own + 1) % NREQ; m_own = -1; m_cnt = 0; m_fin = 0;
    end else if (m_fin) begin
      m_ptr = (m_own + 1) % NREQ; m_own = -1; m_fin = 0;
    end else if (t && m_cnt > 0) begin
      m_cnt--;
      m_fin = (m_cnt == 0);
    end
  endtask
  task automatic cyc(input logic r, input logic [NREQ-1:0] q,
                     input logic [NREQ*WIDTH-1:0] lv, input logic t, input logic a);
    int eg;
    rst = r; req = q; load_val = lv; tick = t; abort = a;
    model_step(r, q, lv, t, a);
    @(posedge clk);
    @(negedge clk);
    eg = (m_own >= 0) ? (1 << m_own) : 0;
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(m_own >= 0));
    check("count", 32'(count), 32'(m_cnt));
    check("done", 32'(done), m_fin ? 32'(eg) : 32'd0);
    check("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask
  initial begin
    logic [NREQ-1:0] prev;
    int served[$];
    int guard;
    rst = 1'b1; req = '0; load_val = '0; tick = 1'b0; abort = 1'b0;
    cyc(1, 2'b11, 8'hFF, 1, 0);
    cyc(1, 2'b11, 8'hFF, 1, 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_count", 32'(count), 0);
    cyc(0, 2'b01, 8'h03, 1, 0);
    check("single_grant", 32'(grant), 1);
    check("single_count", 32'(count), 3);
    cyc(0, 2'b00, 8'h03, 1, 0);
    cyc(0, 2'b00, 8'h03, 1, 0);
    cyc(0, 2'b00, 8'h03, 1, 0);
    check("single_done", 32'(done), 1);
    check("single_zero", 32'(count), 0);
    cyc(0, 2'b00, 8'h03, 1, 0);
    check("single_release", 32'(grant), 0);
    check("single_done_off", 32'(done), 0);
    cyc(0, 2'b10, 8'h00, 0, 0);
    check("zero_grant", 32'(grant), 2);
    check("zero_busy", 32'(busy), 1);
    check("zero_done", 32'(done), 2);
    cyc(0, 2'b00, 8'h00, 0, 0);
    prev = '0;
    for (int c = 0; c < 16; c++) begin
      cyc(0, 2'b11, 8'h22, 1, 0);
      if (grant != 0 && prev == 0) served.push_back(int'(grant));
      prev = grant;
    end
    check("fair_jobs", 32'(served.size()), 4);
    for (int s = 0; s < 4 && s < served.size(); s++)
      check("fair_order", 32'(served[s]), (s % 2 == 0) ? 32'd1 : 32'd2);
    cyc(0, 2'b11, 8'h22, 0, 0);
    check("fair_ptr0", 32'(grant), 1);
    cyc(0, 2'b00, 8'h22, 0, 1);
    cyc(0, 2'b01, 8'h05, 0, 0);
    check("abort_load", 32'(count), 5);
    for (int c = 0; c < 4; c++) cyc(0, 2'b00, 8'h05, 1, 0);
    check("abort_at1", 32'(count), 1);
    cyc(0, 2'b00, 8'h05, 1, 1);
    check("abort_grant", 32'(grant), 0);
    check("abort_count", 32'(count), 0);
    check("abort_nodone", 32'(done), 0);
    cyc(0, 2'b11, 8'h33, 0, 0);
    check("abort_ptr", 32'(grant), 2);
    cyc(0, 2'b00, 8'h33, 0, 1);
    cyc(0, 2'b01, 8'h0F, 0, 0);
    check("sparse_load", 32'(count), 15);
    guard = 0;
    while (m_cnt != 9 && guard < 60) begin
      cyc(0, 2'b00, 8'h0F, (guard % 3 == 2), 0);
      guard++;
    end
    check("sparse_reach9", 32'(count), 9);
    cyc(1, 2'b00, 8'h0F, 1, 0);
    check("sparse_rst_grant", 32'(grant), 0);
    check("sparse_rst_count", 32'(count), 0);
    check("sparse_rst_done", 32'(done), 0);
    for (int c = 0; c < 2000; c++)
      cyc($urandom_range(99) == 0, NREQ'($urandom), (NREQ*WIDTH)'($urandom),
          $urandom_range(9) < 7, $urandom_range(19) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
